// File: rtl/fsm_feed_pkg.sv
// Shared types and defaults for the fsm_stim_feeder stimulus stage.
package fsm_feed_pkg;

  localparam logic [7:0]  IDLE_BYTE_DEF  = 8'h00;
  localparam int unsigned GAP_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    STREAM,
    GAP
  } feed_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } feed_entry_t;

endpackage

// File: rtl/fsm_stim_feeder_if.sv
// Host-side byte handshake into the feeder; host is master, feeder is slave.
interface fsm_stim_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/fsm_feed_fifo.sv
// Synchronous show-ahead FIFO of {last, data} entries; DEPTH must be a power of 2.
module fsm_feed_fifo
  import fsm_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  feed_entry_t              wr_entry,
  input  logic                     pop,
  output feed_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  feed_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsm_stim_feeder.sv
// Frame feeder: buffers host bytes, pulses start, then streams one byte per cycle.
// Optional FEEDER_STATS_EN adds frames_sent / underrun_cnt counters.
module fsm_stim_feeder
  import fsm_feed_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter logic [7:0]  IDLE_BYTE  = IDLE_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fsm_stim_feeder_if.slave     host,
  output logic                 start,
  output logic [7:0]           data_in,
  output logic                 busy,
  output logic                 underrun
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]          frames_sent,
  output logic [7:0]           underrun_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  feed_state_t   state;
  feed_entry_t   fifo_head;
  feed_entry_t   wr_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] frames_pending;
  logic [GW-1:0] gap_cnt;
  logic          last_q;
  logic          push;
  logic          pop;
  logic          launch_ok;

  assign host.in_ready = (fifo_count != CNT_FULL);
  assign push          = host.in_valid && host.in_ready;
  assign wr_entry      = '{last: host.in_last, data: host.in_data};

  // last_q marks that data_in currently shows the frame's final byte, so no further pop.
  assign pop = (state == LAUNCH) || ((state == STREAM) && !last_q && !fifo_empty);

  // A full FIFO with no complete frame launches anyway so an oversize frame can drain.
  assign launch_ok = (frames_pending != '0) || fifo_full;

  fsm_feed_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_pending <= '0;
    end else begin
      case ({push && host.in_last, pop && fifo_head.last})
        2'b10:   frames_pending <= frames_pending + CNT_ONE;
        2'b01:   frames_pending <= frames_pending - CNT_ONE;
        default: frames_pending <= frames_pending;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start    <= 1'b0;
      data_in  <= IDLE_BYTE;
      busy     <= 1'b0;
      underrun <= 1'b0;
      last_q   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      start    <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_ok) begin
            start <= 1'b1;
            busy  <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          data_in <= fifo_head.data;
          last_q  <= fifo_head.last;
          state   <= STREAM;
        end
        STREAM: begin
          if (last_q) begin
            data_in <= IDLE_BYTE;
            last_q  <= 1'b0;
            if (GAP_CYCLES != 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else if (launch_ok) begin
              start <= 1'b1;
              state <= LAUNCH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (!fifo_empty) begin
            data_in <= fifo_head.data;
            last_q  <= fifo_head.last;
          end else begin
            data_in  <= IDLE_BYTE;
            underrun <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (launch_ok) begin
            start <= 1'b1;
            state <= LAUNCH;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_sent  <= '0;
      underrun_cnt <= '0;
    end else begin
      if (start) frames_sent <= frames_sent + 16'd1;
      if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_stim_feeder.sv
// Scoreboard bench for fsm_stim_feeder: driver queues accepted bytes, negedge monitor checks the stream.
module tb_fsm_stim_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 2;
  localparam logic [7:0]  IDLEB = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic       busy;
  logic       underrun;
`ifdef FEEDER_STATS_EN
  logic [15:0] frames_sent;
  logic [7:0]  underrun_cnt;
`endif

  fsm_stim_feeder_if hif ();

  fsm_stim_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .IDLE_BYTE(IDLEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (hif),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .underrun (underrun)
`ifdef FEEDER_STATS_EN
    ,
    .frames_sent  (frames_sent),
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Model of accepted-but-not-yet-shown bytes, plus running totals.
  ent_t        exp_q[$];
  int unsigned pushed_total = 0;
  int unsigned last_pushed  = 0;
  int unsigned shown_total  = 0;
  int unsigned last_shown   = 0;
  int unsigned starts       = 0;
  int unsigned unders       = 0;
  bit          in_frame     = 0;
  int unsigned gap_left     = 0;
  bit          exp_start    = 0;
  int unsigned prev_avail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; gap_left = 0; exp_start = 0; prev_avail = 0;
      shown_total = 0; last_shown = 0; starts = 0; unders = 0;
    end else begin
      ent_t e;
      chk("start", start, exp_start);
      if (exp_start) begin
        starts++;
        chk("launch_busy", busy, 1);
        chk("launch_byte", data_in, IDLEB);
        in_frame = 1;
      end else if (in_frame) begin
        chk("stream_busy", busy, 1);
        if (prev_avail == 0) begin
          unders++;
          chk("underrun_set", underrun, 1);
          chk("underrun_byte", data_in, IDLEB);
        end else begin
          e = exp_q.pop_front();
          chk("underrun_clr", underrun, 0);
          chk("data", data_in, e.data);
          shown_total++;
          if (e.last) begin
            last_shown++;
            in_frame = 0;
            gap_left = GAP;
          end
        end
      end else begin
        chk("idle_byte", data_in, IDLEB);
        chk("idle_underrun", underrun, 0);
        chk("gap_busy", busy, (gap_left > 0));
        if (gap_left > 0) gap_left--;
      end
      chk("in_ready", hif.in_ready, ((pushed_total - shown_total) < DEPTH));
      prev_avail = exp_q.size();
      exp_start = !exp_start && !in_frame && (gap_left == 0) &&
                  ((last_pushed > last_shown) || (pushed_total - shown_total == DEPTH));
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int unsigned waited = 0;
    @(negedge clk);
    hif.in_valid = 1'b1;
    hif.in_data  = d;
    hif.in_last  = l;
    #4;
    while (!hif.in_ready) begin
      waited++;
      if (waited > 200) begin
        chk("send_timeout", 0, 1);
        hif.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #4;
    end
    exp_q.push_back('{data: d, last: l});
    pushed_total++;
    if (l) last_pushed++;
    @(posedge clk);
    #1 hif.in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    hif.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int unsigned c = 0;
    while ((exp_q.size() != 0 || busy || in_frame) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("drain_done", (c < 400), 1);
    idle(2);
  endtask

  task automatic send_frame(input int unsigned len, input int unsigned stall_after,
                            input int unsigned stall_len);
    for (int unsigned i = 0; i < len; i++) begin
      send_byte(8'($urandom), (i == len - 1));
      if (i == stall_after) idle(stall_len);
    end
  endtask

  initial begin
    logic [7:0] f1 [3];
    int unsigned c;
    rst_n = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_data  = '0;
    hif.in_last  = 1'b0;
    #1;
    chk("rst_start", start, 0);
    chk("rst_data_in", data_in, IDLEB);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_in_ready", hif.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);

    // Directed: 3-byte frame back-to-back, then two 1-byte frames queued together.
    f1[0] = 8'h01; f1[1] = 8'h0A; f1[2] = 8'h80;
    for (int unsigned i = 0; i < 3; i++) send_byte(f1[i], (i == 2));
    drain();
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    drain();

    // Host stalls two cycles after byte1 of a 4-byte frame.
    send_frame(4, 1, 2);
    drain();

    // Oversize 20-byte frame forces a full-FIFO launch.
    send_frame(20, 99, 0);
    drain();

    // Randomised frames with random host stalls.
    for (int unsigned f = 0; f < 150; f++) begin
      int unsigned len;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 6);
      for (int unsigned i = 0; i < len; i++) begin
        send_byte(8'($urandom), (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 4));
    end
    drain();

    // Reset during the second stream cycle.
    for (int unsigned i = 0; i < 6; i++) send_byte(8'(8'h30 + i), (i == 5));
    c = 0;
    while (!start && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("reset_test_launch_seen", (c < 50), 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_start", start, 0);
    chk("midrst_data_in", data_in, IDLEB);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", hif.in_ready, 1);
    exp_q.delete();
    pushed_total = 0;
    last_pushed  = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(12);
    send_frame(3, 99, 0);
    drain();

`ifdef FEEDER_STATS_EN
    chk("frames_sent", frames_sent, 32'(16'(starts)));
    chk("underrun_cnt", underrun_cnt, (unders > 255) ? 32'd255 : unders);
`endif
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
